text_fetch_seq: RTL and testbench

- Text-mode fetch sequencer sitting directly upstream of the 8-bit parallel-in/serial-out pixel shifter.
- Per 8-pixel character cell: reads a char/attribute word from video RAM, then the matching font-row byte from the font region.
- Drives the shifter's parallel data, parallel-enable and clock-enable, so each font byte loads exactly on the cell boundary.
- Attribute is presented aligned with the shifted pixels.

---
 rtl/text_fetch_seq_pkg.sv | 33 +++
 rtl/text_fetch_seq_if.sv | 32 +++
 rtl/text_fetch_seq.sv | 156 +++++++++++++++
 tb/tb_text_fetch_seq.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_fetch_seq_pkg.sv
// Shared definitions for the text-mode fetch sequencer: FSM encoding, the
// per-cell phase schedule and the debug view of the sequencer state.
package text_fetch_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Fixed read latency of video memory, counted in pixel ticks.
    localparam int MEM_LATENCY = 2;

    // Per-cell schedule: each capture sits MEM_LATENCY phases after its address.
    localparam logic [2:0] PH_CHAR_ADDR = 3'd0;
    localparam logic [2:0] PH_CHAR_CAP  = 3'(PH_CHAR_ADDR + MEM_LATENCY);
    localparam logic [2:0] PH_FONT_ADDR = 3'(PH_CHAR_CAP + 1);
    localparam logic [2:0] PH_FONT_CAP  = 3'(PH_FONT_ADDR + MEM_LATENCY);
    localparam logic [2:0] PH_LOAD      = 3'd7;

    typedef struct packed {
        state_e     state;
        logic [2:0] phase;
        logic [7:0] col;
    } dbg_t;

    // Offset of a font row inside the font region: 8 rows per glyph.
    function automatic logic [10:0] font_offset(input logic [7:0] code,
                                                input logic [2:0] row);
        return {code, row};
    endfunction

endpackage

// File: rtl/text_fetch_seq_if.sv
// Video-memory read port plus the parallel-load side of the pixel shifter.
// Protocol: no valid/ready. A read address held at phase p returns data that
// is valid at phase p+MEM_LATENCY; the shifter loads sr_d on any cp edge where
// sr_ce_n and sr_pe_n are both low, and shifts on edges where only sr_ce_n is low.
interface text_fetch_seq_if #(
    parameter int ADDR_W = 14
);
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_rdata;
    logic [7:0]        sr_d;
    logic              sr_pe_n;
    logic              sr_ce_n;
    logic [7:0]        attr;

    modport master (
        output mem_addr,
        input  mem_rdata,
        output sr_d,
        output sr_pe_n,
        output sr_ce_n,
        output attr
    );

    modport slave (
        input  mem_addr,
        output mem_rdata,
        input  sr_d,
        input  sr_pe_n,
        input  sr_ce_n,
        input  attr
    );
endinterface

// File: rtl/text_fetch_seq.sv
// Text-mode fetch sequencer: char/attr read, font-row read, shifter load per cell.
// Define TEXT_FETCH_ATTR_EN to capture attributes; otherwise attr is tied low.
module text_fetch_seq
    import text_fetch_seq_pkg::*;
#(
    parameter int                COLUMNS   = 40,
    parameter int                ADDR_W    = 14,
    parameter logic [ADDR_W-1:0] FONT_BASE = ADDR_W'('h3800)
) (
    input  logic              cp,
    input  logic              mr_n,
    input  logic              pix_en,
    input  logic              line_start,
    input  logic [ADDR_W-1:0] row_base,
    input  logic [2:0]        font_row,
    text_fetch_seq_if.master  bus,
    output logic              busy,
    output dbg_t              dbg
);

    localparam logic [7:0] LAST_COL = 8'(COLUMNS - 1);

    state_e            state, state_n;
    logic [2:0]        phase, phase_n;
    logic [7:0]        col, col_n;
    logic [ADDR_W-1:0] base_q, base_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [2:0]        row_q, row_n;
    logic [7:0]        font_pend, font_n;
    logic              restart;
    logic              load_slot;

    assign restart = pix_en & line_start;

    // A restart on the phase-7 tick suppresses the load of the aborted cell.
    assign load_slot = (state != ST_IDLE) && (phase == PH_LOAD) && !restart;

    always_ff @(posedge cp or negedge mr_n) begin
        if (!mr_n) begin
            state     <= ST_IDLE;
            phase     <= '0;
            col       <= '0;
            base_q    <= '0;
            addr_q    <= '0;
            row_q     <= '0;
            font_pend <= '0;
        end else begin
            state     <= state_n;
            phase     <= phase_n;
            col       <= col_n;
            base_q    <= base_n;
            addr_q    <= addr_n;
            row_q     <= row_n;
            font_pend <= font_n;
        end
    end

    always_comb begin
        state_n = state;
        phase_n = phase;
        col_n   = col;
        base_n  = base_q;
        addr_n  = addr_q;
        row_n   = row_q;
        font_n  = font_pend;
        if (restart) begin
            state_n = ST_FETCH;
            phase_n = PH_CHAR_ADDR;
            col_n   = '0;
            base_n  = row_base;
            row_n   = font_row;
            addr_n  = row_base;
            font_n  = '0;
        end else if (pix_en) begin
            unique case (state)
                ST_IDLE: ;
                ST_FETCH: begin
                    phase_n = phase + 3'd1;
                    case (phase)
                        PH_CHAR_CAP:
                            addr_n = FONT_BASE
                                   + ADDR_W'(font_offset(bus.mem_rdata[7:0], row_q));
                        PH_FONT_CAP:
                            font_n = bus.mem_rdata[7:0];
                        PH_LOAD: begin
                            col_n = col + 8'd1;
                            if (col == LAST_COL) begin
                                state_n = ST_DRAIN;
                            end else begin
                                addr_n = base_q + ADDR_W'(col + 8'd1);
                            end
                        end
                        default: ;
                    endcase
                end
                ST_DRAIN: begin
                    phase_n = phase + 3'd1;
                    if (phase == PH_LOAD) begin
                        state_n = ST_IDLE;
                        col_n   = '0;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // The drain slot loads zero so the shifter blanks after the last cell.
    assign bus.sr_d     = (load_slot && state == ST_FETCH) ? font_pend : 8'h00;
    assign bus.sr_pe_n  = ~load_slot;
    assign bus.sr_ce_n  = ~pix_en;
    assign bus.mem_addr = addr_q;
    assign busy         = (state != ST_IDLE);

    assign dbg.state = state;
    assign dbg.phase = phase;
    assign dbg.col   = col;

`ifdef TEXT_FETCH_ATTR_EN
    logic [7:0] attr_pend, attr_pend_n;
    logic [7:0] attr_q, attr_n;

    always_ff @(posedge cp or negedge mr_n) begin
        if (!mr_n) begin
            attr_pend <= '0;
            attr_q    <= '0;
        end else begin
            attr_pend <= attr_pend_n;
            attr_q    <= attr_n;
        end
    end

    // attr changes on the same edge the shifter loads, keeping it pixel-aligned.
    always_comb begin
        attr_pend_n = attr_pend;
        attr_n      = attr_q;
        if (restart) begin
            attr_pend_n = '0;
        end else if (pix_en) begin
            if (state == ST_FETCH && phase == PH_CHAR_CAP) begin
                attr_pend_n = bus.mem_rdata[15:8];
            end
            if (load_slot) begin
                attr_n = (state == ST_FETCH) ? attr_pend : 8'h00;
            end
        end
    end

    assign bus.attr = attr_q;
`else
    logic unused_attr_bits;
    assign unused_attr_bits = ^bus.mem_rdata[15:8];
    assign bus.attr = 8'h00;
`endif

endmodule

// File: tb/tb_text_fetch_seq.sv
// Directed bench for text_fetch_seq with a 2-cycle video memory and an hc166-style shifter.
module tb_text_fetch_seq;
  import text_fetch_seq_pkg::*;

  localparam int ADDR_W = 14;
  localparam int COLUMNS = 40;
  localparam logic [13:0] FONT_BASE = 14'h3800;
`ifdef TEXT_FETCH_ATTR_EN
  localparam logic [7:0] EXP_ATTR = 8'h1E;
`else
  localparam logic [7:0] EXP_ATTR = 8'h00;
`endif

  // clock / reset / stimulus signals
  logic cp = 1'b0;
  logic mr_n;
  logic pix_en;
  logic line_start;
  logic [13:0] row_base;
  logic [2:0] font_row;
  logic busy;
  dbg_t dbg;

  int n_checks = 0;
  int n_pass = 0;

  text_fetch_seq_if #(.ADDR_W(ADDR_W)) bus ();

  text_fetch_seq #(
    .COLUMNS(COLUMNS),
    .ADDR_W(ADDR_W),
    .FONT_BASE(FONT_BASE)
  ) dut (
    .cp(cp),
    .mr_n(mr_n),
    .pix_en(pix_en),
    .line_start(line_start),
    .row_base(row_base),
    .font_row(font_row),
    .bus(bus.master),
    .busy(busy),
    .dbg(dbg)
  );

  always #5 cp = ~cp;

  // video memory, 2-cycle read latency
  logic [15:0] mem [0:16383];
  logic [13:0] addr_d1;
  always @(posedge cp) begin
    addr_d1 <= bus.mem_addr;
    bus.mem_rdata <= mem[addr_d1];
  end

  // downstream shifter
  logic [7:0] sr_q = 8'h00;
  always @(posedge cp) begin
    if (!bus.sr_ce_n) begin
      if (!bus.sr_pe_n) sr_q <= bus.sr_d;
      else sr_q <= {sr_q[6:0], 1'b0};
    end
  end

  // scoreboard capture of every shifter load and of busy ticks
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int busy_ticks = 0;
  always @(negedge cp) begin
    if (pix_en && !bus.sr_pe_n) got_q.push_back(bus.sr_d);
    if (busy && pix_en) busy_ticks++;
  end

  // expected font byte for column c of a line starting at base
  function automatic logic [7:0] font_exp(input logic [13:0] base, input int c, input logic [2:0] row);
    logic [13:0] ca;
    logic [13:0] fa;
    ca = base + 14'(c);
    fa = FONT_BASE + {3'b000, mem[ca][7:0], row};
    return mem[fa][7:0];
  endfunction

  // driver tasks
  task automatic step();
    @(posedge cp);
    #1;
  endtask

  task automatic do_reset();
    @(negedge cp);
    mr_n = 1'b0;
    pix_en = 1'b0;
    line_start = 1'b0;
    @(negedge cp);
    mr_n = 1'b1;
  endtask

  task automatic start_line(input logic [13:0] base, input logic [2:0] row);
    row_base = base;
    font_row = row;
    line_start = 1'b1;
    step();
    line_start = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      step();
      pix_en = (i % 2) == 1;
      #1;
      n_checks++;
      if ({bus.sr_ce_n, bus.sr_pe_n, bus.sr_d, bus.attr, busy, bus.mem_addr, dbg.state} !==
          {~pix_en, 1'b1, 8'h00, 8'h00, 1'b0, 14'h0000, ST_IDLE})
        $display("FAIL reset[%0d]: ce_n=%b pe_n=%b sr_d=%h attr=%h busy=%b addr=%h state=%0d, want ce_n=%b pe_n=1 sr_d=00 attr=00 busy=0 addr=0000 state=0",
                 i, bus.sr_ce_n, bus.sr_pe_n, bus.sr_d, bus.attr, busy, bus.mem_addr, dbg.state, ~pix_en);
      else n_pass++;
    end
    @(negedge cp);
    mr_n = 1'b1;
  endtask

  task automatic test_basic_cell();
    logic [7:0] bits;
    pix_en = 1'b1;
    start_line(14'h100, 3'd3);
    n_checks++;
    if ({dbg.state, dbg.phase, busy, bus.mem_addr} !== {ST_FETCH, 3'd0, 1'b1, 14'h0100})
      $display("FAIL char_addr: state=%0d phase=%0d busy=%b addr=%h, want 1 0 1 0100", dbg.state, dbg.phase, busy, bus.mem_addr);
    else n_pass++;
    repeat (3) step();
    n_checks++;
    if ({dbg.phase, bus.mem_addr} !== {3'd3, 14'h3A0B})
      $display("FAIL font_addr: phase=%0d addr=%h, want 3 3a0b", dbg.phase, bus.mem_addr);
    else n_pass++;
    repeat (3) step();
    n_checks++;
    if (bus.sr_pe_n !== 1'b1)
      $display("FAIL pe_idle: phase=%0d pe_n=%b, want 1", dbg.phase, bus.sr_pe_n);
    else n_pass++;
    step();
    n_checks++;
    if ({dbg.phase, bus.sr_pe_n, bus.sr_d} !== {3'd7, 1'b0, 8'hA5})
      $display("FAIL load_slot: phase=%0d pe_n=%b sr_d=%h, want 7 0 a5", dbg.phase, bus.sr_pe_n, bus.sr_d);
    else n_pass++;
    bits = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      else begin
        step();
        n_checks++;
        if ({bus.attr, bus.sr_pe_n, dbg.col, dbg.phase} !== {EXP_ATTR, 1'b1, 8'd1, 3'd0})
          $display("FAIL after_load: attr=%h pe_n=%b col=%0d phase=%0d, want %h 1 1 0", bus.attr, bus.sr_pe_n, dbg.col, dbg.phase, EXP_ATTR);
        else n_pass++;
      end
      bits = {bits[6:0], sr_q[7]};
    end
    n_checks++;
    if (bits !== 8'hA5)
      $display("FAIL q7_seq: got %b, want 10100101", bits);
    else n_pass++;
  endtask

  task automatic test_pix_en_freeze();
    logic [13:0] exp_addr;
    logic [7:0] exp_font;
    do_reset();
    pix_en = 1'b1;
    start_line(14'h200, 3'd1);
    repeat (4) step();
    exp_addr = FONT_BASE + {3'b000, mem[14'h200][7:0], 3'd1};
    exp_font = font_exp(14'h200, 0, 3'd1);
    pix_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      n_checks++;
      if ({dbg.state, dbg.phase, dbg.col, bus.mem_addr, bus.sr_pe_n, bus.sr_ce_n, busy} !==
          {ST_FETCH, 3'd4, 8'd0, exp_addr, 1'b1, 1'b1, 1'b1})
        $display("FAIL freeze[%0d]: state=%0d phase=%0d col=%0d addr=%h pe_n=%b ce_n=%b busy=%b, want 1 4 0 %h 1 1 1",
                 i, dbg.state, dbg.phase, dbg.col, bus.mem_addr, bus.sr_pe_n, bus.sr_ce_n, busy, exp_addr);
      else n_pass++;
    end
    pix_en = 1'b1;
    repeat (3) step();
    n_checks++;
    if ({bus.sr_pe_n, bus.sr_d} !== {1'b0, exp_font})
      $display("FAIL resume_slot: pe_n=%b sr_d=%h, want 0 %h", bus.sr_pe_n, bus.sr_d, exp_font);
    else n_pass++;
    step();
    n_checks++;
    if (sr_q !== exp_font)
      $display("FAIL resume_load: shifter=%h, want %h", sr_q, exp_font);
    else n_pass++;
  endtask

  task automatic test_full_line();
    int got_base;
    int tick_base;
    int n_got;
    do_reset();
    exp_q.delete();
    for (int c = 0; c < COLUMNS; c++) exp_q.push_back(font_exp(14'h3FF0, c, 3'd5));
    exp_q.push_back(8'h00);
    got_base = got_q.size();
    tick_base = busy_ticks;
    pix_en = 1'b1;
    start_line(14'h3FF0, 3'd5);
    for (int cyc = 0; cyc < 2000 && busy; cyc++) begin
      pix_en = (cyc % 3) != 2;
      step();
    end
    pix_en = 1'b1;
    n_checks++;
    if (busy !== 1'b0)
      $display("FAIL line_timeout: busy=%b after 2000 cycles, want 0", busy);
    else n_pass++;
    n_got = got_q.size() - got_base;
    n_checks++;
    if (n_got !== exp_q.size())
      $display("FAIL load_count: got %0d loads, want %0d", n_got, exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < n_got; i++) begin
      n_checks++;
      if (got_q[got_base + i] !== exp_q[i])
        $display("FAIL load_data[%0d]: sr_d=%h, want %h", i, got_q[got_base + i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (busy_ticks - tick_base !== (COLUMNS + 1) * 8)
      $display("FAIL busy_ticks: got %0d, want %0d", busy_ticks - tick_base, (COLUMNS + 1) * 8);
    else n_pass++;
    n_checks++;
    if ({sr_q, bus.attr, dbg.state} !== {8'h00, 8'h00, ST_IDLE})
      $display("FAIL blank: shifter=%h attr=%h state=%0d, want 00 00 0", sr_q, bus.attr, dbg.state);
    else n_pass++;
  endtask

  task automatic test_restart();
    int got_base;
    logic [7:0] exp_new;
    do_reset();
    pix_en = 1'b1;
    got_base = got_q.size();
    start_line(14'h100, 3'd3);
    repeat (44) step();
    n_checks++;
    if ({dbg.col, dbg.phase} !== {8'd5, 3'd4})
      $display("FAIL restart_pos: col=%0d phase=%0d, want 5 4", dbg.col, dbg.phase);
    else n_pass++;
    start_line(14'h300, 3'd2);
    n_checks++;
    if ({dbg.state, dbg.phase, dbg.col, bus.mem_addr} !== {ST_FETCH, 3'd0, 8'd0, 14'h0300})
      $display("FAIL restart_state: state=%0d phase=%0d col=%0d addr=%h, want 1 0 0 0300", dbg.state, dbg.phase, dbg.col, bus.mem_addr);
    else n_pass++;
    n_checks++;
    if (got_q.size() - got_base !== 5)
      $display("FAIL restart_loads: got %0d loads before restart, want 5", got_q.size() - got_base);
    else n_pass++;
    for (int c = 0; c < 5 && got_base + c < got_q.size(); c++) begin
      n_checks++;
      if (got_q[got_base + c] !== font_exp(14'h100, c, 3'd3))
        $display("FAIL restart_data[%0d]: sr_d=%h, want %h", c, got_q[got_base + c], font_exp(14'h100, c, 3'd3));
      else n_pass++;
    end
    repeat (8) step();
    exp_new = font_exp(14'h300, 0, 3'd2);
    n_checks++;
    if (got_q.size() - got_base !== 6 || got_q[got_q.size() - 1] !== exp_new)
      $display("FAIL restart_first: loads=%0d last=%h, want 6 %h", got_q.size() - got_base, got_q[got_q.size() - 1], exp_new);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    pix_en = 1'b1;
    start_line(14'h0C0, 3'd6);
    repeat (86) step();
    n_checks++;
    if ({dbg.col, dbg.phase, busy} !== {8'd10, 3'd6, 1'b1})
      $display("FAIL mid_pos: col=%0d phase=%0d busy=%b, want 10 6 1", dbg.col, dbg.phase, busy);
    else n_pass++;
    #2;
    mr_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, bus.mem_addr, bus.sr_pe_n, bus.sr_d, bus.attr, dbg.state, dbg.phase, dbg.col} !==
        {1'b0, 14'h0000, 1'b1, 8'h00, 8'h00, ST_IDLE, 3'd0, 8'd0})
      $display("FAIL async_reset: busy=%b addr=%h pe_n=%b sr_d=%h attr=%h state=%0d phase=%0d col=%0d, want 0 0000 1 00 00 0 0 0",
               busy, bus.mem_addr, bus.sr_pe_n, bus.sr_d, bus.attr, dbg.state, dbg.phase, dbg.col);
    else n_pass++;
    @(negedge cp);
    mr_n = 1'b1;
  endtask

  initial begin
    mr_n = 1'b0;
    pix_en = 1'b0;
    line_start = 1'b0;
    row_base = 14'h0000;
    font_row = 3'd0;
    for (int i = 0; i < 16384; i++) mem[i] = {8'(i * 7 + 3), 8'((i * 13) ^ (i >> 6))};
    mem[14'h0100] = 16'h1E41;
    mem[14'h3A0B] = 16'h00A5;
    test_reset();
    test_basic_cell();
    test_pix_en_freeze();
    test_full_line();
    test_restart();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
